// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command/response driver for the combinational 8-bit ALU
// Optional accumulate chaining is compiled in with `define ALU_CHAIN_EN (adds cmd_chain).
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
`ifdef ALU_CHAIN_EN
    input  logic             cmd_chain,
`endif
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       capture;
    logic       deliver;
    logic [7:0] a_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Chained commands accumulate onto the previous captured result.
`ifdef ALU_CHAIN_EN
    assign a_src = cmd_chain ? rsp_result : cmd_a;
`else
    assign a_src = cmd_a;
`endif

    // ALU operands persist after completion; only a new accept replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_op     <= 3'd0;
            rsp_tag    <= '0;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            alu_a      <= a_src;
            alu_b      <= cmd_b;
            alu_op     <= cmd_op;
            rsp_tag    <= cmd_tag;
            settle_cnt <= 4'(SETTLE_CYCLES - 1);
        end else if (state == SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= 8'd0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_carry  <= alu_carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (deliver) begin
            op_count <= op_count + 16'd1;
        end
    end

    settle_range_a: assert property (@(posedge clk) (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 15));

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - randomized self-checking bench for alu_cmd_driver
// Set ALU_CHAIN_EN to also exercise accumulate chaining.
module tb_alu_cmd_driver;

    localparam int S = 4;

`ifdef ALU_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic [3:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic        cmd_chain;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_carry;
    logic        rsp_valid, rsp_ready, rsp_zero, rsp_carry, busy;
    logic [7:0]  rsp_result;
    logic [3:0]  rsp_tag;
    logic [15:0] op_count;

    logic        d1_cmd_valid, d1_cmd_ready;
    logic [7:0]  d1_alu_a, d1_alu_b, d1_alu_result;
    logic [2:0]  d1_alu_op;
    logic        d1_alu_zero, d1_alu_carry;
    logic        d1_rsp_valid, d1_rsp_ready, d1_rsp_zero, d1_rsp_carry, d1_busy;
    logic [7:0]  d1_rsp_result;
    logic [3:0]  d1_rsp_tag;
    logic [15:0] d1_op_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        exp_q[$];
    logic [7:0]  last_res = 8'd0;
    logic [15:0] exp_cnt  = 16'd0;
    logic [7:0]  exp_a, exp_b;
    logic [2:0]  exp_op;
    int          acc_wait;

    always #5 clk = ~clk;

    alu_cmd_driver #(.SETTLE_CYCLES(S), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
`ifdef ALU_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_tag(rsp_tag), .busy(busy), .op_count(op_count)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(1), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
`ifdef ALU_CHAIN_EN
        .cmd_chain(cmd_chain),
`endif
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op(d1_alu_op),
        .alu_result(d1_alu_result), .alu_zero(d1_alu_zero), .alu_carry(d1_alu_carry),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready),
        .rsp_result(d1_rsp_result), .rsp_zero(d1_rsp_zero), .rsp_carry(d1_rsp_carry),
        .rsp_tag(d1_rsp_tag), .busy(d1_busy), .op_count(d1_op_count)
    );

    // ALU behaviour: bit 8 is carry (or borrow for subtract)
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {1'b0, 1'b0, a[7:1]};
        endcase
    endfunction

    always_comb begin
        {alu_carry, alu_result}       = alu_fn(alu_a, alu_b, alu_op);
        alu_zero                      = (alu_result == 8'd0);
        {d1_alu_carry, d1_alu_result} = alu_fn(d1_alu_a, d1_alu_b, d1_alu_op);
        d1_alu_zero                   = (d1_alu_result == 8'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                            input logic [3:0] tag, input logic chain);
        exp_t       e;
        logic [8:0] r;
        exp_a  = chain ? last_res : a;
        exp_b  = b;
        exp_op = op;
        r      = alu_fn(exp_a, b, op);
        e      = '{res: r[7:0], z: (r[7:0] == 8'd0), c: r[8], tag: tag};
        exp_q.push_back(e);
        last_res  = r[7:0];
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        acc_wait  = 0;
        while (!cmd_ready && acc_wait < 50) begin
            @(negedge clk);
            acc_wait++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("alu_load", {alu_a, alu_b, alu_op}, {exp_a, exp_b, exp_op});
        check("busy_after_accept", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_rsp(input int delay);
        exp_t e;
        int   lat = 0;
        while (!rsp_valid && lat < 40) begin
            check("alu_hold", {alu_a, alu_b, alu_op}, {exp_a, exp_b, exp_op});
            check("settle_ready", cmd_ready, 0);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, S);
        e = exp_q.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_flags", {rsp_zero, rsp_carry}, {e.z, e.c});
        check("rsp_tag", rsp_tag, e.tag);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_tag},
                  {1'b1, e.res, e.z, e.c, e.tag});
            check("bp_ready", {cmd_ready, op_count}, {1'b0, exp_cnt});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt++;
        check("op_count", op_count, exp_cnt);
        check("post_hs", {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    task automatic run_d1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic [3:0] tag, input logic [15:0] cnt);
        logic [8:0] r;
        r            = alu_fn(a, b, op);
        cmd_a        = a;
        cmd_b        = b;
        cmd_op       = op;
        cmd_tag      = tag;
        cmd_chain    = 1'b0;
        d1_cmd_valid = 1'b1;
        d1_rsp_ready = 1'b1;
        check("d1_ready", d1_cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        d1_cmd_valid = 1'b0;
        check("d1_not_early", d1_rsp_valid, 0);
        @(negedge clk);
        check("d1_valid", d1_rsp_valid, 1);
        check("d1_result", d1_rsp_result, r[7:0]);
        check("d1_flags", {d1_rsp_zero, d1_rsp_carry}, {(r[7:0] == 8'd0), r[8]});
        check("d1_tag", d1_rsp_tag, tag);
        @(negedge clk);
        check("d1_done", {d1_rsp_valid, d1_op_count}, {1'b0, cnt});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 3'd0; cmd_tag = 4'd0;
        cmd_chain = 1'b0; rsp_ready = 1'b0; d1_cmd_valid = 1'b0; d1_rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {cmd_ready, rsp_valid, busy}, 3'b100);
        check("rst_count", op_count, 0);
        check("rst_alu", {alu_a, alu_b, alu_op}, 0);
        check("rst_rsp", {rsp_result, rsp_zero, rsp_carry, rsp_tag}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_d1(8'h12, 8'h34, 3'd0, 4'd3, 16'd1);
        run_d1(8'hFF, 8'h01, 3'd0, 4'd7, 16'd2);
        check("d1_carry_zero", {d1_rsp_result, d1_rsp_zero, d1_rsp_carry}, {8'h00, 1'b1, 1'b1});

        send_cmd(8'h12, 8'h34, 3'd0, 4'd3, 1'b0);
        wait_rsp(0);
        check("basic_result", rsp_result, 8'h46);
        send_cmd(8'hFF, 8'h01, 3'd0, 4'd5, 1'b0);
        wait_rsp(1);
        check("carry_zero", {rsp_result, rsp_zero, rsp_carry}, {8'h00, 1'b1, 1'b1});

        // second command waits on the channel through a long stall
        send_cmd(8'h20, 8'h22, 3'd1, 4'd9, 1'b0);
        cmd_a = 8'h40; cmd_b = 8'h03; cmd_op = 3'd4; cmd_tag = 4'd10; cmd_valid = 1'b1;
        wait_rsp(10);
        send_cmd(8'h40, 8'h03, 3'd4, 4'd10, 1'b0);
        check("accept_after_hs", acc_wait, 0);
        wait_rsp(0);
        check("alu_kept_idle", {alu_a, alu_b, alu_op}, {8'h40, 8'h03, 3'd4});

`ifdef ALU_CHAIN_EN
        send_cmd(8'h05, 8'h03, 3'd0, 4'd1, 1'b0);
        wait_rsp(0);
        send_cmd(8'hAA, 8'h02, 3'd0, 4'd2, 1'b1);
        wait_rsp(0);
        check("chain_result", rsp_result, 8'h0A);
`endif

        for (int k = 0; k < 30; k++) begin
            send_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)), CHAIN ? 1'($urandom_range(0, 1)) : 1'b0);
            wait_rsp(int'($urandom_range(0, 3)));
        end

        // abandon an operation mid-settle
        send_cmd(8'h11, 8'h22, 3'd0, 4'd6, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {rsp_valid, cmd_ready, busy}, 3'b010);
        check("rst_mid_count", op_count, 0);
        check("rst_mid_regs", {alu_a, rsp_result, rsp_tag}, 0);
        exp_q.delete();
        exp_cnt  = 16'd0;
        last_res = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (S + 3) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_rst", {seen, op_count}, 0);

        send_cmd(8'h0F, 8'hF1, 3'd0, 4'd4, 1'b0);
        wait_rsp(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
